// File: rtl/sha1_io_pkg.sv
// Shared widths and select codes for the board-side SHA-1 I/O path.
// Imported by the switch capture logic and the core/display logic.
package sha1_io_pkg;

  localparam int H0_W  = 5;
  localparam int H1_W  = 5;
  localparam int H2_W  = 5;
  localparam int H3_W  = 3;
  localparam int SW_W  = 5;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_H0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_H1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_H2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_H3 = 2'd3;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-bit flop-chain synchroniser with a synchronous active-high clear.
// STAGES must be at least 2.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_handler.sv
// Captures the slide-switch value into one of four holding registers on each
// push-button press; all board inputs are synchronised before use.
module switch_handler
  import sha1_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] h_select,
  input  logic [SW_W-1:0]  SW,
  input  logic             push,
  output logic [H0_W-1:0]  h0,
  output logic [H1_W-1:0]  h1,
  output logic [H2_W-1:0]  h2,
  output logic [H3_W-1:0]  h3
);

  logic             push_s;
  logic             push_prev;
  logic             load_pulse;
  logic [SEL_W-1:0] sel_s;
  logic [SW_W-1:0]  sw_s;

  // Equal chain depths keep select and data aligned with the button edge.
  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_push (
    .clk (clk),
    .rst (rst),
    .d   (push),
    .q   (push_s)
  );

  sync_ff #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sync_sel (
    .clk (clk),
    .rst (rst),
    .d   (h_select),
    .q   (sel_s)
  );

  sync_ff #(.WIDTH(SW_W), .STAGES(SYNC_STAGES)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .d   (SW),
    .q   (sw_s)
  );

  always_ff @(posedge clk) begin
    if (rst) push_prev <= 1'b0;
    else     push_prev <= push_s;
  end

  assign load_pulse = push_s & ~push_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else if (load_pulse) begin
      case (sel_s)
        SEL_H0:  h0 <= sw_s[H0_W-1:0];
        SEL_H1:  h1 <= sw_s[H1_W-1:0];
        SEL_H2:  h2 <= sw_s[H2_W-1:0];
        default: h3 <= sw_s[H3_W-1:0];  // upper switch bits dropped for h3
      endcase
    end
  end

endmodule

// File: tb/tb_switch_handler.sv
// Directed bench for switch_handler: reset, latency, per-register loads,
// held-button, reset-during-load and push-held-through-reset cases.
module tb_switch_handler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] h_select;
  logic [4:0] sw;
  logic       push;
  logic [4:0] h0, h1, h2;
  logic [2:0] h3;

  logic [4:0] e0, e1, e2;
  logic [2:0] e3;

  int vectors = 0;
  int miscompares = 0;

  switch_handler #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .h_select (h_select),
    .SW       (sw),
    .push     (push),
    .h0       (h0),
    .h1       (h1),
    .h2       (h2),
    .h3       (h3)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".h0"}, h0, e0);
    check({tag, ".h1"}, h1, e1);
    check({tag, ".h2"}, h2, e2);
    check({tag, ".h3"}, {2'b00, h3}, {2'b00, e3});
  endtask

  // Two-cycle press, then enough idle cycles for push_s to fall again.
  task automatic press(input logic [1:0] sel, input logic [4:0] val);
    h_select = sel;
    sw       = val;
    push     = 1'b1;
    tick(2);
    push = 1'b0;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; h_select = 2'b00; sw = 5'b0;
    e0 = '0; e1 = '0; e2 = '0; e3 = '0;
    tick(1);

    // 1) presses while in reset are discarded
    h_select = 2'b00; sw = 5'b00110;
    for (int i = 0; i < 5; i++) begin
      push = ~push;
      tick(1);
      check_all("rst_hold");
    end
    rst = 1'b0; push = 1'b0;
    tick(3);
    check_all("post_rst");

    // 2) first load and its latency
    h_select = 2'b00; sw = 5'b00110; push = 1'b1;
    tick(2);
    check("lat_edge2.h0", h0, 5'b00000);
    push = 1'b0;
    tick(1);
    check("lat_edge3.h0", h0, 5'b00110);
    e0 = 5'b00110;
    tick(3);
    check_all("load_h0");

    // 3) h1 overwritten, h2 loaded, h0 untouched
    press(2'b01, 5'b00110); e1 = 5'b00110;
    check_all("load_h1a");
    press(2'b10, 5'b10011); e2 = 5'b10011;
    check_all("load_h2");
    press(2'b01, 5'b00010); e1 = 5'b00010;
    check_all("load_h1b");

    // 4) h3 keeps only SW[2:0]
    press(2'b11, 5'b00101); e3 = 3'b101;
    check_all("load_h3a");
    press(2'b11, 5'b11111); e3 = 3'b111;
    check_all("load_h3b");

    // 5) long hold with changing inputs: one load of the values at the rise
    h_select = 2'b00; sw = 5'b11000; push = 1'b1;
    tick(2);
    for (int i = 0; i < 18; i++) begin
      h_select = 2'(i + 1);
      sw       = 5'(i * 7 + 3);
      tick(1);
    end
    push = 1'b0;
    tick(4);
    e0 = 5'b11000;
    check_all("long_hold");

    // 6) reset coincident with load_pulse wins
    h_select = 2'b01; sw = 5'b11111; push = 1'b1;
    tick(2);
    rst = 1'b1; push = 1'b0;
    tick(1);
    e0 = '0; e1 = '0; e2 = '0; e3 = '0;
    check_all("rst_vs_load");
    rst = 1'b0;
    tick(4);
    check_all("after_rst_vs_load");

    // 7) push held through reset release gives exactly one load
    rst = 1'b1; push = 1'b1; h_select = 2'b10; sw = 5'b01010;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("held_rel_edge2.h2", h2, 5'b00000);
    tick(1);
    check("held_rel_edge3.h2", h2, 5'b01010);
    e2 = 5'b01010;
    sw = 5'b00001;
    tick(5);
    push = 1'b0;
    tick(4);
    check_all("held_rel_once");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
